// File: rtl/pattern_game_ctrl.sv
// pattern_game_ctrl: colour-memory game controller.
// Generates a growing random colour sequence from a 16-bit Galois LFSR.
// Presents the sequence one colour at a time, then checks player entries
// from the colour sensor and reports progress through message codes.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   start        one-cycle pulse, starts a game from IDLE
//   color        player colour from sensor
//   color_valid  one-cycle strobe qualifying color
//   msg          0 SHOW, 4 READY, 5 CORRECT, 6 WRONG, 7 COMPLETE, 8 SCORE
//   show_color   colour being presented (valid when msg == 0)
//   level        current sequence length
//   score        correct entries in the current/last game
//   high_score   best final score since reset
//   buzzer       high while the WRONG message is displayed
//   busy         high in every state except IDLE
//
// Build option: define HIGH_SCORE_EN to implement the high_score register;
// without it high_score is tied to zero.
module pattern_game_ctrl #(
  parameter int unsigned COLOR_BITS  = 2,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned SHOW_TICKS  = 20,
  parameter int unsigned INPUT_TICKS = 50,
  parameter int unsigned TICK_DIV    = 800000,
  parameter int unsigned SCORE_BITS  = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [COLOR_BITS-1:0]        color,
  input  logic                         color_valid,
  output logic [3:0]                   msg,
  output logic [COLOR_BITS-1:0]        show_color,
  output logic [$clog2(MAX_LEN+1)-1:0] level,
  output logic [SCORE_BITS-1:0]        score,
  output logic [SCORE_BITS-1:0]        high_score,
  output logic                         buzzer,
  output logic                         busy
);

  localparam int unsigned LVL_W   = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TMR_MAX = (SHOW_TICKS > INPUT_TICKS) ? SHOW_TICKS : INPUT_TICKS;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [3:0] MSG_SHOW     = 4'd0;
  localparam logic [3:0] MSG_READY    = 4'd4;
  localparam logic [3:0] MSG_CORRECT  = 4'd5;
  localparam logic [3:0] MSG_WRONG    = 4'd6;
  localparam logic [3:0] MSG_COMPLETE = 4'd7;
  localparam logic [3:0] MSG_SCORE    = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_SHOW,
    S_WAIT_IN,
    S_CORRECT,
    S_WRONG,
    S_WIN
  } state_t;

  state_t                  state, state_d;
  logic [TICK_W-1:0]       tick_cnt;
  logic                    tick;
  logic [15:0]             lfsr, lfsr_step;
  logic [COLOR_BITS-1:0]   seq [MAX_LEN];
  logic [LVL_W-1:0]        idx, idx_d;
  logic [TMR_W-1:0]        timer, timer_d;
  logic [LVL_W-1:0]        level_d;
  logic [SCORE_BITS-1:0]   score_d;
  logic [3:0]              msg_d;
  logic [COLOR_BITS-1:0]   show_color_d;
  logic                    wr_en;
  logic [IDX_W-1:0]        wr_idx;
  logic [COLOR_BITS-1:0]   new_color;

  // Free-running game tick: one clk pulse every TICK_DIV cycles
  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Galois LFSR x^16+x^14+x^13+x^11+1, stepped every clk
  assign lfsr_step = {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);
  assign new_color = lfsr[COLOR_BITS-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= LFSR_SEED;
    else        lfsr <= lfsr_step;
  end

  // Sequence storage; entries persist across rounds, only GEN writes
  assign wr_idx = IDX_W'(level);

  always_ff @(posedge clk) begin
    if (wr_en) seq[wr_idx] <= new_color;
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      timer      <= '0;
      level      <= '0;
      score      <= '0;
      msg        <= MSG_SCORE;
      show_color <= '0;
      buzzer     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      timer      <= timer_d;
      level      <= level_d;
      score      <= score_d;
      msg        <= msg_d;
      show_color <= show_color_d;
      buzzer     <= (state_d == S_WRONG);
      busy       <= (state_d != S_IDLE);
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    timer_d      = timer;
    level_d      = level;
    score_d      = score;
    wr_en        = 1'b0;
    msg_d        = msg;
    show_color_d = show_color;

    case (state)
      S_IDLE: begin
        if (start) begin
          score_d = '0;
          level_d = '0;
          state_d = S_GEN;
        end
      end

      S_GEN: begin
        wr_en   = 1'b1;
        level_d = level + LVL_W'(1);
        idx_d   = '0;
        timer_d = '0;
        state_d = S_SHOW;
      end

      S_SHOW: begin
        if (tick) begin
          if (timer == TMR_W'(SHOW_TICKS - 1)) begin
            timer_d = '0;
            if (idx + LVL_W'(1) == level) begin
              idx_d   = '0;
              state_d = S_WAIT_IN;
            end else begin
              idx_d = idx + LVL_W'(1);
            end
          end else begin
            timer_d = timer + TMR_W'(1);
          end
        end
      end

      // An entry takes priority over a timeout tick in the same cycle
      S_WAIT_IN: begin
        if (color_valid) begin
          timer_d = '0;
          if (color == seq[IDX_W'(idx)]) begin
            if (score != '1) score_d = score + SCORE_BITS'(1);
            if (idx + LVL_W'(1) == level) begin
              idx_d   = '0;
              state_d = S_CORRECT;
            end else begin
              idx_d = idx + LVL_W'(1);
            end
          end else begin
            state_d = S_WRONG;
          end
        end else if (tick) begin
          if (timer == TMR_W'(INPUT_TICKS - 1)) begin
            timer_d = '0;
            state_d = S_WRONG;
          end else begin
            timer_d = timer + TMR_W'(1);
          end
        end
      end

      S_CORRECT: begin
        if (tick) begin
          if (timer == TMR_W'(SHOW_TICKS - 1)) begin
            timer_d = '0;
            state_d = (level == LVL_W'(MAX_LEN)) ? S_WIN : S_GEN;
          end else begin
            timer_d = timer + TMR_W'(1);
          end
        end
      end

      S_WRONG, S_WIN: begin
        if (tick) begin
          if (timer == TMR_W'(SHOW_TICKS - 1)) begin
            timer_d = '0;
            state_d = S_IDLE;
          end else begin
            timer_d = timer + TMR_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Message follows the next state; GEN keeps the previous message
    case (state_d)
      S_IDLE:    msg_d = MSG_SCORE;
      S_SHOW:    msg_d = MSG_SHOW;
      S_WAIT_IN: msg_d = MSG_READY;
      S_CORRECT: msg_d = MSG_CORRECT;
      S_WRONG:   msg_d = MSG_WRONG;
      S_WIN:     msg_d = MSG_COMPLETE;
      default:   msg_d = msg;
    endcase

    // Bypass the colour being written this cycle when it is shown next
    if (state_d == S_SHOW) begin
      if (wr_en && (IDX_W'(idx_d) == wr_idx)) show_color_d = new_color;
      else                                    show_color_d = seq[IDX_W'(idx_d)];
    end
  end

`ifdef HIGH_SCORE_EN
  // Capture the final score when a game ends on WRONG or WIN
  logic hs_upd;
  assign hs_upd = ((state == S_WRONG) || (state == S_WIN)) &&
                  (state_d == S_IDLE) && (score > high_score);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      high_score <= '0;
    else if (hs_upd) high_score <= score;
  end
`else
  assign high_score = '0;
`endif

endmodule

// File: tb/tb_pattern_game_ctrl.sv
`timescale 1ns/1ps
module tb_pattern_game_ctrl;

  localparam int unsigned CB = 2;
  localparam int unsigned ML = 3;
  localparam int unsigned ST = 2;
  localparam int unsigned IT = 5;
  localparam int unsigned TD = 4;
  localparam int unsigned SB = 8;
  localparam int unsigned LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CB-1:0] color = '0;
  logic          color_valid = 1'b0;
  logic [3:0]    msg;
  logic [CB-1:0] show_color;
  logic [LW-1:0] level;
  logic [SB-1:0] score;
  logic [SB-1:0] high_score;
  logic          buzzer;
  logic          busy;

  always #5 clk = ~clk;

  pattern_game_ctrl #(
    .COLOR_BITS (CB),
    .MAX_LEN    (ML),
    .SHOW_TICKS (ST),
    .INPUT_TICKS(IT),
    .TICK_DIV   (TD),
    .SCORE_BITS (SB),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .color      (color),
    .color_valid(color_valid),
    .msg        (msg),
    .show_color (show_color),
    .level      (level),
    .score      (score),
    .high_score (high_score),
    .buzzer     (buzzer),
    .busy       (busy)
  );

  // Reference timebase: clk edges since reset release and the LFSR value
  int unsigned edges;
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      edges  <= 0;
      m_lfsr <= 16'hACE1;
    end else begin
      edges  <= edges + 1;
      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  int total = 0;
  int bad   = 0;
  int exp_score = 0;
  int exp_level = 0;
  int exp_hs    = 0;
  bit poke      = 1'b0;
  logic [CB-1:0] q_seq[$];

  // A game tick happens on every TD-th edge after reset release
  function automatic bit tick_next();
    return ((edges + 1) % TD) == 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".msg"},    32'(msg), 32'd8);
    chk({tag, ".busy"},   32'(busy), 32'd0);
    chk({tag, ".buzzer"}, 32'(buzzer), 32'd0);
    chk({tag, ".score"},  32'(score), 32'(exp_score));
    chk({tag, ".level"},  32'(level), 32'(exp_level));
    chk({tag, ".hs"},     32'(high_score), 32'(exp_hs));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".msg"},    32'(msg), 32'd8);
    chk({tag, ".color"},  32'(show_color), 32'd0);
    chk({tag, ".level"},  32'(level), 32'd0);
    chk({tag, ".score"},  32'(score), 32'd0);
    chk({tag, ".hs"},     32'(high_score), 32'd0);
    chk({tag, ".buzzer"}, 32'(buzzer), 32'd0);
    chk({tag, ".busy"},   32'(busy), 32'd0);
  endtask

  // Message m must stay for exactly ST game ticks
  task automatic hold(input logic [3:0] m, input bit with_color, input logic [CB-1:0] c,
                      input string tag);
    int t = 0;
    while (t < ST) begin
      chk({tag, ".msg"}, 32'(msg), 32'(m));
      if (with_color) chk({tag, ".color"}, 32'(show_color), 32'(c));
      chk({tag, ".buzzer"}, 32'(buzzer), (m == 4'd6) ? 32'd1 : 32'd0);
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      if (poke) begin
        start       = 1'b1;
        color_valid = 1'b1;
        color       = c;
      end
      if (tick_next()) t++;
      step();
      if (poke) begin
        start       = 1'b0;
        color_valid = 1'b0;
        poke        = 1'b0;
      end
    end
  endtask

  // Idle in READY; returns when the next edge should carry the entry,
  // or (to_timeout) after the edge that exhausts INPUT_TICKS
  task automatic wait_entry(input bit to_timeout, input bit late);
    int tk = 0;
    int c  = 0;
    int d  = int'($urandom_range(0, 10));
    bit wt;
    forever begin
      wt = tick_next();
      if (to_timeout) begin
        if (tk == IT) break;
      end else if (late) begin
        if (wt && (tk + 1 == IT)) break;
      end else if ((c == d) || (wt && (tk + 1 == IT))) begin
        break;
      end
      chk("wait.msg", 32'(msg), 32'd4);
      if (wt) tk++;
      step();
      c++;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_score = 0;
    exp_level = 0;
    q_seq.delete();
    chk("gen.busy",  32'(busy), 32'd1);
    chk("gen.score", 32'(score), 32'd0);
    chk("gen.level", 32'(level), 32'd0);
  endtask

  // One whole game; fail_lvl == 0 plays through to COMPLETE
  task automatic play(input int fail_lvl, input int fail_idx, input bit timeout,
                      input bit late, input bit poke_show);
    bit failed = 1'b0;
    do_start();
    for (int lv = 1; lv <= int'(ML); lv++) begin
      q_seq.push_back(m_lfsr[CB-1:0]);
      step();
      exp_level = lv;
      chk("show.level", 32'(level), 32'(lv));
      if (poke_show && lv == 1) poke = 1'b1;
      for (int i = 0; i < lv; i++) hold(4'd0, 1'b1, q_seq[i], "show");
      chk("ready.msg", 32'(msg), 32'd4);
      for (int i = 0; i < lv; i++) begin
        if (lv == fail_lvl && i == fail_idx) begin
          if (timeout) begin
            wait_entry(1'b1, 1'b0);
          end else begin
            wait_entry(1'b0, late);
            color_valid = 1'b1;
            color       = q_seq[i] ^ CB'(1);
            step();
            color_valid = 1'b0;
          end
          failed = 1'b1;
          break;
        end
        wait_entry(1'b0, late);
        color_valid = 1'b1;
        color       = q_seq[i];
        step();
        color_valid = 1'b0;
        if (exp_score < 255) exp_score++;
        chk("entry.score", 32'(score), 32'(exp_score));
        chk("entry.msg", 32'(msg), (i < lv - 1) ? 32'd4 : 32'd5);
      end
      if (failed) break;
      hold(4'd5, 1'b0, '0, "correct");
    end
    if (failed) hold(4'd6, 1'b0, '0, "wrong");
    else        hold(4'd7, 1'b0, '0, "win");
`ifdef HIGH_SCORE_EN
    if (exp_score > exp_hs) exp_hs = exp_score;
`endif
    check_idle("end");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl, fi;
    step();
    check_reset_vals("rst");
    step();
    reset = 1'b1;
    repeat (int'($urandom_range(0, 7))) step();
    check_idle("idle0");

    // Full game with strobes injected during SHOW, all ignored
    play(0, 0, 1'b0, 1'b0, 1'b1);
    // Wrong colour at level 2, second entry
    play(2, 1, 1'b0, 1'b0, 1'b0);
    // No entry at level 1: timeout
    play(1, 0, 1'b1, 1'b0, 1'b0);
    // Every entry coincides with the timeout tick and must be accepted
    play(0, 0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of SHOW
    do_start();
    q_seq.push_back(m_lfsr[CB-1:0]);
    step();
    step();
    chk("pre_rst.msg", 32'(msg), 32'd0);
    reset = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    exp_score = 0;
    exp_level = 0;
    exp_hs    = 0;
    step();
    step();
    reset = 1'b1;
    step();
    check_idle("post_rst");

    // Randomised games
    for (int g = 0; g < 6; g++) begin
      repeat (int'($urandom_range(0, 6))) step();
      fl = int'($urandom_range(0, ML));
      fi = (fl > 0) ? int'($urandom_range(0, fl - 1)) : 0;
      play(fl, fi, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
